// File: rtl/processor_pio_pkg.sv
// rtl/processor_pio_pkg.sv - shared register addresses and edge-type encodings for PIO blocks
package processor_pio_pkg;

    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Select which state transitions count as events for the chosen edge type.
    function automatic logic edge_event(input logic cur, input logic nxt, input int edge_type);
        logic rise;
        logic fall;
        rise = nxt & ~cur;
        fall = cur & ~nxt;
        case (edge_type)
            EDGE_RISE: edge_event = rise;
            EDGE_FALL: edge_event = fall;
            default:   edge_event = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - two-flop synchroniser plus hold-time debounce for one input bit
module pio_debounce_bit #(
    parameter int   DB_CYCLES = 50000,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic state_o,
    output logic state_next_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while the synchronised input disagrees with the accepted state; accept on the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain, accepted state and hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            state_q <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/processor_keys_in.sv
// rtl/processor_keys_in.sv - debounced input PIO slave with edge capture and masked interrupt
module processor_keys_in
    import processor_pio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DB_CYCLES = 50000,
    parameter int               EDGE_TYPE = 2,
    parameter logic [WIDTH-1:0] IN_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             unused_wd;

    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr_en     = chipselect & ~write_n;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .DB_CYCLES (DB_CYCLES),
                .RST_VAL   (IN_RESET[gi])
            ) u_db (
                .clk          (clk),
                .reset_n      (reset_n),
                .in_i         (in_port[gi]),
                .state_o      (state[gi]),
                .state_next_o (state_next[gi])
            );
            assign ev[gi] = edge_event(state[gi], state_next[gi], EDGE_TYPE);
        end
    endgenerate

    // Mask write and edge capture; a new event outranks a same-cycle W1C clear.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == PIO_IRQMASK) begin
            irqmask_d = wdata;
        end
        if (wr_en && address == PIO_EDGECAP) begin
            edgecap_d = edgecap_q & ~wdata;
        end
        edgecap_d = edgecap_d | ev;
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-latency read mux; the reserved slot and unused upper bits read zero.
    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:    readdata = 32'(state);
            PIO_IRQMASK: readdata = 32'(irqmask_q);
            PIO_EDGECAP: readdata = 32'(edgecap_q);
            default:     readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_processor_keys_in.sv
// tb/tb_processor_keys_in.sv - self-checking bench for processor_keys_in
module tb_processor_keys_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    processor_keys_in #(
        .WIDTH     (8),
        .DB_CYCLES (4),
        .EDGE_TYPE (2),
        .IN_RESET  (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp_data;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Push the expectation, present the read, pop and compare mid-cycle.
    task automatic chk(input logic [1:0] a, input logic [31:0] ed, input logic ei, input string nm);
        vec_t v;
        vec_t e;
        v.addr = a; v.exp_data = ed; v.exp_irq = ei; v.name = nm;
        sb_q.push_back(v);
        address = a;
        @(negedge clk);
        e = sb_q.pop_front();
        total++;
        if (readdata !== e.exp_data) begin
            bad++;
            $display("FAIL %s readdata: got %h want %h", e.name, readdata, e.exp_data);
        end
        total++;
        if (irq !== e.exp_irq) begin
            bad++;
            $display("FAIL %s irq: got %b want %b", e.name, irq, e.exp_irq);
        end
    endtask

    vec_t reset_tbl[4];
    vec_t final_tbl[4];

    initial begin
        reset_tbl[0] = '{2'd0, 32'h0, 1'b0, "rst_data"};
        reset_tbl[1] = '{2'd1, 32'h0, 1'b0, "rst_resv"};
        reset_tbl[2] = '{2'd2, 32'h0, 1'b0, "rst_mask"};
        reset_tbl[3] = '{2'd3, 32'h0, 1'b0, "rst_edge"};
        final_tbl[0] = '{2'd0, 32'hFF, 1'b1, "t6_data_after_wr"};
        final_tbl[1] = '{2'd1, 32'h0,  1'b1, "t6_resv_after_wr"};
        final_tbl[2] = '{2'd2, 32'hFF, 1'b1, "t6_mask_upper0"};
        final_tbl[3] = '{2'd3, 32'hFF, 1'b1, "t6_edgecap"};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // 1: reset values
        for (int i = 0; i < 4; i++) chk(reset_tbl[i].addr, reset_tbl[i].exp_data, reset_tbl[i].exp_irq, reset_tbl[i].name);

        // 2: acceptance latency of exactly 6 clk
        in_port = 8'h05;
        tick(5);
        chk(2'd0, 32'h00, 1'b0, "t2_data_before");
        tick(1);
        chk(2'd0, 32'h05, 1'b0, "t2_data_at6");
        chk(2'd3, 32'h05, 1'b0, "t2_edgecap");

        // 3: mask raises irq, W1C clears it
        wr(2'd2, 32'h01);
        chk(2'd2, 32'h01, 1'b1, "t3_mask_irq");
        wr(2'd3, 32'h01);
        chk(2'd3, 32'h04, 1'b0, "t3_w1c");

        // 4a: 3-clk glitch on bit 3 is rejected
        in_port = 8'h0D;
        tick(3);
        in_port = 8'h05;
        tick(10);
        chk(2'd0, 32'h05, 1'b0, "t4_glitch_data");
        chk(2'd3, 32'h04, 1'b0, "t4_glitch_edge");

        // 4b: 6-clk pulse on bit 3 captures rise then fall
        in_port = 8'h0D;
        tick(6);
        in_port = 8'h05;
        tick(1);
        chk(2'd0, 32'h0D, 1'b0, "t4_pulse_data_hi");
        chk(2'd3, 32'h0C, 1'b0, "t4_rise_cap");
        wr(2'd3, 32'h08);
        chk(2'd3, 32'h04, 1'b0, "t4_rise_cleared");
        tick(5);
        chk(2'd0, 32'h05, 1'b0, "t4_pulse_data_lo");
        chk(2'd3, 32'h0C, 1'b0, "t4_fall_cap");

        // 5: W1C on bit 0 in the clk bit 0 captures a fall -> set wins
        in_port = 8'h04;
        tick(5);
        chk(2'd0, 32'h05, 1'b0, "t5_data_before");
        wr(2'd3, 32'h01);
        chk(2'd0, 32'h04, 1'b1, "t5_data_after");
        chk(2'd3, 32'h0D, 1'b1, "t5_set_wins");

        // 6: reset mid-debounce discards the partial count
        in_port = 8'hFF;
        tick(4);
        reset_n = 1'b0;
        #2;
        chk(2'd0, 32'h00, 1'b0, "t6_async_rst_data");
        chk(2'd3, 32'h00, 1'b0, "t6_async_rst_edge");
        tick(1);
        reset_n = 1'b1;
        tick(5);
        chk(2'd0, 32'h00, 1'b0, "t6_data_before");
        tick(1);
        chk(2'd0, 32'hFF, 1'b0, "t6_data_at6");
        wr(2'd0, 32'h00);
        wr(2'd1, 32'hAB);
        wr(2'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) chk(final_tbl[i].addr, final_tbl[i].exp_data, final_tbl[i].exp_irq, final_tbl[i].name);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
